// File: rtl/lane_data_receiver_if.sv
// Note-lane stream bundle between the lane generator (master) and the
// lane data receiver (slave). The master drives the strobe and lane value.
// The slave returns the decoded lane and the sync status.
interface lane_data_receiver_if;
    logic       map;
    logic       data_en;
    logic [7:0] data;
    logic [2:0] lane;
    logic       lane_valid;
    logic       wrap_pulse;
    logic       locked;
    logic       sync_err;
    logic [7:0] err_count;

    modport master (
        output map, data_en, data,
        input  lane, lane_valid, wrap_pulse, locked, sync_err, err_count
    );

    modport slave (
        input  map, data_en, data,
        output lane, lane_valid, wrap_pulse, locked, sync_err, err_count
    );
endinterface

// File: rtl/lane_data_receiver.sv
// Lane data receiver: the consumer end of the repeating note-lane sequence.
// It samples on map && data_en and searches for a legal value. It verifies
// LOCK_COUNT in-order samples before locking. While locked it decodes the
// lane index and flywheels through isolated bad samples. It falls back to
// search after ERR_MAX consecutive misses.
module lane_data_receiver #(
    parameter int BASE       = 100,
    parameter int STEP       = 4,
    parameter int LAST       = 116,
    parameter int LOCK_COUNT = 3,
    parameter int ERR_MAX    = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    lane_data_receiver_if.slave   bus
);

    localparam logic [7:0] C_BASE = 8'(BASE);
    localparam logic [7:0] C_STEP = 8'(STEP);
    localparam logic [7:0] C_LAST = 8'(LAST);
    localparam logic [7:0] C_LOCK = 8'(LOCK_COUNT);
    localparam logic [7:0] C_EMAX = 8'(ERR_MAX);
    localparam int         SHIFT  = $clog2(STEP);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    // The value that follows v in the sequence, wrapping LAST back to BASE.
    function automatic logic [7:0] f_next(input logic [7:0] v);
        return (v == C_LAST) ? C_BASE : v + C_STEP;
    endfunction

    // A value is a sequence member if it is in range and on the step grid.
    function automatic logic f_legal(input logic [7:0] v);
        return (v >= C_BASE) && (v <= C_LAST) &&
               (((v - C_BASE) & (C_STEP - 8'd1)) == 8'd0);
    endfunction

    // Lane index of an in-sequence value. STEP is a power of two, so this is a shift.
    function automatic logic [2:0] f_lane(input logic [7:0] v);
        return 3'((v - C_BASE) >> SHIFT);
    endfunction

    // Error counter increment that sticks at full scale.
    function automatic logic [7:0] f_sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_exp;
    logic [7:0] w_exp_nxt;
    logic [7:0] r_good_cnt;
    logic [7:0] w_good_nxt;
    logic [7:0] r_miss_run;
    logic [7:0] w_miss_nxt;
    logic [2:0] r_lane;
    logic [2:0] w_lane_nxt;
    logic       r_lane_valid;
    logic       w_lane_valid_nxt;
    logic       r_wrap_pulse;
    logic       w_wrap_nxt;
    logic       r_locked;
    logic       r_sync_err;
    logic       w_sync_err_nxt;
    logic [7:0] r_err_count;
    logic [7:0] w_err_count_nxt;

    logic       w_sample;
    logic       w_match;
    logic [7:0] w_good_inc;
    logic [7:0] w_miss_inc;

    assign w_sample   = bus.map && bus.data_en;
    assign w_match    = (bus.data == r_exp);
    assign w_good_inc = r_good_cnt + 8'd1;
    assign w_miss_inc = r_miss_run + 8'd1;

    // State and datapath registers; everything returns to search on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_SEARCH;
            r_exp        <= C_BASE;
            r_good_cnt   <= 8'd0;
            r_miss_run   <= 8'd0;
            r_lane       <= 3'd0;
            r_lane_valid <= 1'b0;
            r_wrap_pulse <= 1'b0;
            r_locked     <= 1'b0;
            r_sync_err   <= 1'b0;
            r_err_count  <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_exp        <= w_exp_nxt;
            r_good_cnt   <= w_good_nxt;
            r_miss_run   <= w_miss_nxt;
            r_lane       <= w_lane_nxt;
            r_lane_valid <= w_lane_valid_nxt;
            r_wrap_pulse <= w_wrap_nxt;
            r_locked     <= (w_state_nxt == S_LOCKED);
            r_sync_err   <= w_sync_err_nxt;
            r_err_count  <= w_err_count_nxt;
        end
    end

    // Next-state and next-output decode. Nothing moves without a sample event.
    always_comb begin
        w_state_nxt      = r_state;
        w_exp_nxt        = r_exp;
        w_good_nxt       = r_good_cnt;
        w_miss_nxt       = r_miss_run;
        w_lane_nxt       = r_lane;
        w_lane_valid_nxt = 1'b0;
        w_wrap_nxt       = 1'b0;
        w_sync_err_nxt   = 1'b0;
        w_err_count_nxt  = r_err_count;

        if (w_sample) begin
            case (r_state)
                S_SEARCH: begin
                    if (f_legal(bus.data)) begin
                        w_exp_nxt   = f_next(bus.data);
                        w_good_nxt  = 8'd1;
                        w_state_nxt = S_VERIFY;
                    end
                end

                S_VERIFY: begin
                    if (w_match) begin
                        w_good_nxt = w_good_inc;
                        w_exp_nxt  = f_next(bus.data);
                        if (w_good_inc == C_LOCK) begin
                            w_state_nxt = S_LOCKED;
                            w_miss_nxt  = 8'd0;
                        end
                    end else begin
                        // A mismatch is discarded, not re-tried as a new candidate.
                        w_state_nxt = S_SEARCH;
                    end
                end

                S_LOCKED: begin
                    // The expected value advances on every sample, good or bad.
                    w_exp_nxt = f_next(r_exp);
                    if (w_match) begin
                        w_lane_valid_nxt = 1'b1;
                        w_lane_nxt       = f_lane(bus.data);
                        w_wrap_nxt       = (bus.data == C_LAST);
                        w_miss_nxt       = 8'd0;
                    end else begin
                        w_sync_err_nxt  = 1'b1;
                        w_err_count_nxt = f_sat_inc(r_err_count);
                        w_miss_nxt      = w_miss_inc;
                        if (w_miss_inc == C_EMAX) begin
                            w_state_nxt = S_SEARCH;
                        end
                    end
                end

                default: begin
                    w_state_nxt = S_SEARCH;
                end
            endcase
        end
    end

    assign bus.lane       = r_lane;
    assign bus.lane_valid = r_lane_valid;
    assign bus.wrap_pulse = r_wrap_pulse;
    assign bus.locked     = r_locked;
    assign bus.sync_err   = r_sync_err;
    assign bus.err_count  = r_err_count;

endmodule

// File: doc/lane_data_receiver.md
# lane_data_receiver

Consumer end of the note-lane data stream in the game datapath. Samples `data`/`data_en` on each `map` strobe, acquires lock on the repeating lane sequence (100, 104, 108, 112, 116, 100, …), and reports the decoded lane index to downstream note logic. It flywheels through isolated corrupt samples and counts sync errors. It drops back to search after repeated mismatches.

## Interface
Parameters:
- `BASE`, 100, first value of the sequence; the value after a wrap.
- `STEP`, 4, increment between samples; must be a power of two.
- `LAST`, 116, final value before wrap; `(LAST-BASE)/STEP` must be ≤ 7.
- `LOCK_COUNT`, 3, consecutive in-sequence samples required to lock (≥ 2).
- `ERR_MAX`, 2, consecutive mismatches in LOCKED that force return to SEARCH (≥ 1).

Ports:
- `clk` in 1: clock.
- `resetn` in 1: asynchronous, active-low reset.
- `map` in 1: sample strobe; same strobe that advances the generator.
- `data_en` in 1: stream-valid from generator.
- `data` in 8: lane value from generator.
- `lane` out 3: decoded lane index `(data-BASE)/STEP`.
- `lane_valid` out 1: one-cycle pulse; `lane` is valid this cycle.
- `wrap_pulse` out 1: one-cycle pulse when the accepted sample equals `LAST`.
- `locked` out 1: high in state LOCKED.
- `sync_err` out 1: one-cycle pulse on a mismatch while LOCKED.
- `err_count` out 8: saturating count of `sync_err` events.

## Operation
- **Sample event:** `map && data_en` at a rising edge. The value captured is `data` as held before that edge's generator update. No sample is taken when `map` is high and `data_en` is low.
- **Legal value:** `BASE ≤ data ≤ LAST` and `(data-BASE) mod STEP == 0`.
- **Next value:** `next(v) = (v == LAST) ? BASE : v + STEP`, 8-bit arithmetic.
- Internal state: `exp[7:0]` (expected value), `good_cnt`, `miss_run`.

State machine, evaluated only on sample events:
- **SEARCH**
  - Legal sample: `exp <= next(data)`, `good_cnt <= 1`, go to VERIFY.
  - Illegal sample: stay in SEARCH.
- **VERIFY**
  - `data == exp`: increment `good_cnt` and set `exp <= next(data)`.
  - When the increment reaches `LOCK_COUNT`, go to LOCKED with `miss_run <= 0`.
  - Mismatch: go to SEARCH and discard the sample (it is not re-evaluated as a candidate).
- **LOCKED**
  - `data == exp`:
    - Pulse `lane_valid` with `lane = (data-BASE) >> log2(STEP)`.
    - Pulse `wrap_pulse` if `data == LAST`.
    - Set `miss_run <= 0` and `exp <= next(exp)`.
  - Mismatch (including illegal values):
    - Pulse `sync_err` and set `err_count <= min(err_count+1, 255)`.
    - Set `miss_run <= miss_run + 1` and `exp <= next(exp)` (flywheel).
    - If `miss_run + 1 == ERR_MAX`, go to SEARCH.
    - No `lane_valid` is issued for a mismatched sample.
- `lane_valid` is never asserted outside LOCKED, including for the sample that completes lock.
- `err_count` is cleared only by reset and is held across SEARCH/VERIFY.

## Timing
- All outputs are registered. Pulses are high for exactly one cycle, in the cycle after the sampling edge.
- `locked` rises in the cycle after the edge that takes the `LOCK_COUNT`-th good sample. It falls in the cycle after the edge that takes the `ERR_MAX`-th consecutive miss.
- `lane` holds its last value between pulses.
- **Back-to-back:** `map` may be high on consecutive cycles; every cycle is an independent sample with no throughput loss.
- **Reset values** (asynchronous, immediate): state SEARCH, `exp=BASE`, `good_cnt=0`, `miss_run=0`, `lane=0`, `lane_valid=0`, `wrap_pulse=0`, `locked=0`, `sync_err=0`, `err_count=0`.
- **Reset mid-lock:** all of the above take effect immediately. The first sample after release starts from SEARCH.

## Test plan
- **Reset values:** hold `resetn=0` with `map` toggling -> all outputs 0.
- **Lock and decode:**
  - Stimulus: `data_en=1`, strobe `map` while driving 100, 104, 108, 112, 116, 100.
  - Required: `locked`=1 after the 108 sample; no `lane_valid` for 100/104/108.
  - Required: `lane` = 3, 4, 0 with `lane_valid` for 112, 116, 100; `wrap_pulse` with the 116 sample only.
- **Single glitch (locked):** expected 104, drive 105 -> `sync_err` pulse, `err_count`=1, `locked` stays 1. Next sample 108 -> `lane`=2 valid.
- **Loss of lock:** drive two consecutive wrong values (99, 200) -> two `sync_err` pulses, `err_count`=2, `locked`=0. Then 100, 104, 108 relocks.
- **Gated and illegal inputs:**
  - `map` pulses with `data_en=0` -> no state change.
  - In SEARCH, drive 102, 120 -> stays SEARCH. Then 112, 116, 100 -> locks.
- **Saturation and reset:**
  - Force more than 255 mismatch events -> `err_count` holds at 255.
  - Assert `resetn=0` mid-lock -> `locked`=0 and `err_count`=0 immediately.
